// File: rtl/cpu_phase_tracker.sv
// CPU bus phase tracker: synchronises OE/WE strobes, realigns a phase counter on
// each OE assertion, drives the PSRAM pstart window and ce, and tracks period lock.
module cpu_phase_tracker #(
    parameter int unsigned PERIOD    = 24,
    parameter int unsigned SYNC      = 3,
    parameter int unsigned WIN_START = 16,
    parameter int unsigned WIN_END   = 2,
    parameter int unsigned TOL       = 2,
    parameter int unsigned LOCK_CNT  = 4,
    localparam int unsigned PW       = $clog2(PERIOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_oe_n,
    input  logic          cpu_we_n,
    input  logic          en,
    output logic [PW-1:0] phase,
    output logic          cpu_pstart,
    output logic          cpu_ce,
    output logic          oe_rise,
    output logic          we_rise,
    output logic          locked,
    output logic [7:0]    period_meas
);

    localparam int unsigned LW    = $clog2(LOCK_CNT + 1);
    localparam int unsigned TMO_I = (PERIOD * 4 > 255) ? 255 : PERIOD * 4;
    localparam logic [7:0]  TMO   = TMO_I[7:0];

    typedef enum logic {
        S_UNLOCK,
        S_LOCKED
    } lock_state_t;

    logic [SYNC-1:0] r_oe_sync, r_we_sync;
    logic            r_oe_prev, r_we_prev;
    logic            r_oe_rise, r_we_rise;
    logic [PW-1:0]   r_phase;
    logic            r_pstart, r_ce;
    logic [7:0]      r_cnt, r_meas;
    lock_state_t     r_state, w_state_next;
    logic [LW-1:0]   r_lcnt, w_lcnt_next;

    logic            w_oe_s, w_we_s;
    logic            w_inwin, w_pstart_next;
    int unsigned     w_ph;
    logic [7:0]      w_cnt_inc;
    logic [8:0]      w_diff, w_abs;
    logic            w_in_tol;
    logic            w_locked;

    assign w_oe_s = r_oe_sync[SYNC-1];
    assign w_we_s = r_we_sync[SYNC-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oe_sync <= '0;
            r_we_sync <= '0;
            r_oe_prev <= 1'b0;
            r_we_prev <= 1'b0;
            r_oe_rise <= 1'b0;
            r_we_rise <= 1'b0;
        end else begin
            r_oe_sync <= {r_oe_sync[SYNC-2:0], ~cpu_oe_n};
            r_we_sync <= {r_we_sync[SYNC-2:0], ~cpu_we_n};
            r_oe_prev <= w_oe_s;
            r_we_prev <= w_we_s;
            r_oe_rise <= w_oe_s & ~r_oe_prev;
            r_we_rise <= w_we_s & ~r_we_prev;
        end
    end

    always_comb begin
        w_ph = {{(32-PW){1'b0}}, r_phase};
        if (WIN_START <= WIN_END)
            w_inwin = (w_ph >= WIN_START) && (w_ph <= WIN_END);
        else
            w_inwin = (w_ph >= WIN_START) || (w_ph <= WIN_END);
        w_pstart_next = en & w_inwin;
    end

    // An OE edge takes priority over the natural wrap, so the phase never double-wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= '0;
            r_pstart <= 1'b0;
            r_ce     <= 1'b0;
        end else begin
            if (!en || r_oe_rise || r_phase == PW'(PERIOD - 1))
                r_phase <= '0;
            else
                r_phase <= r_phase + 1'b1;
            r_pstart <= w_pstart_next;
            r_ce     <= w_pstart_next | w_oe_s | w_we_s;
        end
    end

    always_comb begin
        w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
        w_diff    = {1'b0, w_cnt_inc} - 9'(PERIOD);
        w_abs     = w_diff[8] ? (9'd0 - w_diff) : w_diff;
        w_in_tol  = (w_abs <= 9'(TOL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_meas <= '0;
        end else if (r_oe_rise) begin
            r_meas <= w_cnt_inc;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_UNLOCK;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_lcnt  <= w_lcnt_next;
        end
    end

    // Tolerance is judged on the measurement being loaded this cycle.
    always_comb begin
        w_state_next = r_state;
        w_lcnt_next  = r_lcnt;
        if (!en) begin
            w_state_next = S_UNLOCK;
            w_lcnt_next  = '0;
        end else if (r_oe_rise) begin
            if (!w_in_tol) begin
                w_state_next = S_UNLOCK;
                w_lcnt_next  = '0;
            end else if (r_state == S_UNLOCK) begin
                if (r_lcnt == LW'(LOCK_CNT - 1)) begin
                    w_state_next = S_LOCKED;
                    w_lcnt_next  = '0;
                end else begin
                    w_lcnt_next = r_lcnt + 1'b1;
                end
            end
        end else if (r_state == S_LOCKED && r_cnt == TMO) begin
            w_state_next = S_UNLOCK;
            w_lcnt_next  = '0;
        end
    end

    always_comb begin
        w_locked = (r_state == S_LOCKED);
    end

    assign phase       = r_phase;
    assign cpu_pstart  = r_pstart;
    assign cpu_ce      = r_ce;
    assign oe_rise     = r_oe_rise;
    assign we_rise     = r_we_rise;
    assign locked      = w_locked;
    assign period_meas = r_meas;

endmodule

// File: tb/tb_cpu_phase_tracker.sv
// Bench for cpu_phase_tracker: directed scenarios plus randomized strobe bursts,
// every cycle compared against a cycle-history reference model.
module tb_cpu_phase_tracker;

    localparam int P     = 24;
    localparam int SY    = 3;
    localparam int WS    = 16;
    localparam int W_END = 2;
    localparam int TL    = 2;
    localparam int LC    = 4;
    localparam int PW    = $clog2(P);
    localparam int TMO   = (P * 4 > 255) ? 255 : P * 4;
    localparam int MAXK  = 16384;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_oe_n = 1'b1;
    logic          cpu_we_n = 1'b1;
    logic          en = 1'b1;
    logic [PW-1:0] phase;
    logic          cpu_pstart, cpu_ce, oe_rise, we_rise, locked;
    logic [7:0]    period_meas;

    int errors = 0;
    int checks = 0;

    cpu_phase_tracker #(
        .PERIOD(P), .SYNC(SY), .WIN_START(WS), .WIN_END(W_END), .TOL(TL), .LOCK_CNT(LC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n), .en(en),
        .phase(phase), .cpu_pstart(cpu_pstart), .cpu_ce(cpu_ce), .oe_rise(oe_rise),
        .we_rise(we_rise), .locked(locked), .period_meas(period_meas)
    );

    always #5 clk = ~clk;

    // Reference model: pin history arrays, phase as distance from last realign point,
    // counter as distance from last measurement point.
    bit hoe[0:MAXK];
    bit hwe[0:MAXK];
    bit soe[0:MAXK];
    bit swe[0:MAXK];
    int k, z, base;
    int m_phase, m_meas, m_lc;
    bit m_pstart, m_ce, m_rise_o, m_rise_w, m_locked;

    function automatic bit inwin(input int p);
        if (WS <= W_END) return (p >= WS) && (p <= W_END);
        return (p >= WS) || (p <= W_END);
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        k = 0; z = 0; base = 0;
        m_phase = 0; m_meas = 0; m_lc = 0;
        m_pstart = 0; m_ce = 0; m_rise_o = 0; m_rise_w = 0; m_locked = 0;
        soe[0] = 0; swe[0] = 0;
    endtask

    task automatic model_edge();
        bit s1o, s2o, s1w, s2w, nro, nrw;
        int cnt_prev, d;
        k++;
        if (k >= MAXK) begin
            $display("FAIL model_range k=%0d limit=%0d", k, MAXK);
            $fatal(1, "model history exhausted");
        end
        hoe[k] = !cpu_oe_n;
        hwe[k] = !cpu_we_n;
        soe[k] = (k >= SY) ? hoe[k-SY+1] : 1'b0;
        swe[k] = (k >= SY) ? hwe[k-SY+1] : 1'b0;
        s1o = soe[k-1]; s1w = swe[k-1];
        s2o = (k >= 2) ? soe[k-2] : 1'b0;
        s2w = (k >= 2) ? swe[k-2] : 1'b0;
        nro = s1o & !s2o;
        nrw = s1w & !s2w;
        cnt_prev = sat255(k - 1 - base);
        m_pstart = en & inwin(m_phase);
        m_ce = m_pstart | s1o | s1w;
        if (!en || m_rise_o) z = k;
        if (m_rise_o) begin
            m_meas = sat255(cnt_prev + 1);
            base = k;
        end
        if (!en) begin
            m_locked = 0; m_lc = 0;
        end else if (m_rise_o) begin
            d = m_meas - P;
            if (d < 0) d = -d;
            if (d > TL) begin
                m_locked = 0; m_lc = 0;
            end else if (!m_locked) begin
                m_lc++;
                if (m_lc == LC) begin
                    m_locked = 1; m_lc = 0;
                end
            end
        end else if (m_locked && cnt_prev == TMO) begin
            m_locked = 0; m_lc = 0;
        end
        m_phase = (k - z) % P;
        m_rise_o = nro;
        m_rise_w = nrw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("phase", 32'(phase), 32'(m_phase));
        chk("cpu_pstart", 32'(cpu_pstart), 32'(m_pstart));
        chk("cpu_ce", 32'(cpu_ce), 32'(m_ce));
        chk("oe_rise", 32'(oe_rise), 32'(m_rise_o));
        chk("we_rise", 32'(we_rise), 32'(m_rise_w));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("period_meas", 32'(period_meas), 32'(m_meas));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_phase"}, 32'(phase), 0);
        chk({tag, "_pstart"}, 32'(cpu_pstart), 0);
        chk({tag, "_ce"}, 32'(cpu_ce), 0);
        chk({tag, "_oe_rise"}, 32'(oe_rise), 0);
        chk({tag, "_we_rise"}, 32'(we_rise), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_meas"}, 32'(period_meas), 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic oe_burst(input int per, input int w);
        for (int c = 0; c < per; c++) begin
            cpu_oe_n = !(c < w);
            step();
        end
        cpu_oe_n = 1'b1;
    endtask

    int we_pulses;
    bit ce_seen;

    initial begin
        // Reset state
        rst_n = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Free run: wrap and window
        for (int i = 0; i < 3 * P; i++) step();

        // Periodic OE at 24, lock after 4 in-tolerance edges
        for (int i = 0; i < 6; i++) oe_burst(P, 3);
        chk("t2_meas24", 32'(period_meas), 24);
        chk("t2_locked", 32'(locked), 1);

        // Period change to 30 drops lock
        oe_burst(30, 3);
        oe_burst(30, 3);
        chk("t3_meas30", 32'(period_meas), 30);
        chk("t3_unlocked", 32'(locked), 0);

        // Relock, then stop OE: timeout and counter saturation
        for (int i = 0; i < 5; i++) oe_burst(P, 3);
        chk("t4_relocked", 32'(locked), 1);
        for (int i = 0; i < 300; i++) step();
        chk("t4_timeout", 32'(locked), 0);
        oe_burst(P, 2);
        chk("t4_meas_sat", 32'(period_meas), 255);

        // OE edge landing on the last phase
        for (int i = 0; i < 4 * P && m_phase != (P - 2 - SY); i++) step();
        chk("t5_align", m_phase, P - 2 - SY);
        cpu_oe_n = 1'b0;
        step(); step();
        cpu_oe_n = 1'b1;
        step(); step();
        chk("t5_ph_last", 32'(phase), P - 1);
        chk("t5_rise", 32'(oe_rise), 1);
        step();
        chk("t5_ph_zero", 32'(phase), 0);

        // WE with en=0
        for (int i = 0; i < 6; i++) step();
        en = 1'b0;
        step();
        cpu_we_n = 1'b0;
        we_pulses = 0; ce_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) cpu_we_n = 1'b1;
            step();
            we_pulses += int'(we_rise);
            ce_seen |= cpu_ce;
            chk("t5_en0_phase", 32'(phase), 0);
            chk("t5_en0_pstart", 32'(cpu_pstart), 0);
        end
        chk("t5_we_pulses", we_pulses, 1);
        chk("t5_ce_seen", 32'(ce_seen), 1);
        en = 1'b1;

        // Mid-window async reset
        for (int i = 0; i < 3 * P && !m_pstart; i++) step();
        chk("t6_in_window", 32'(cpu_pstart), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("t6_async");
        @(negedge clk);
        check_zero("t6_hold");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step();
        chk("t6_resume", 32'(phase), 4);

        // Randomized bursts
        for (int b = 0; b < 60; b++) begin
            int per, w;
            per = (b % 3 == 0) ? $urandom_range(6, 60) : $urandom_range(P - TL - 1, P + TL + 1);
            w = $urandom_range(1, 4);
            en = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < per; c++) begin
                cpu_oe_n = !(c < w);
                cpu_we_n = ($urandom_range(0, 7) != 0);
                step();
            end
        end
        cpu_oe_n = 1'b1; cpu_we_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 10; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
